// File: rtl/addr_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addr_tx_pkg
// Purpose  : Shared types for the address-link transmit sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package addr_tx_pkg;

  localparam int ADDR_W_DEF = 11;

  typedef logic [10:0] link_addr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO. Pushes into a full FIFO and pops from an
//            empty one are ignored, so callers may request either freely.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign dout      = mem_q[rd_ptr_q];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/addr_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : addr_tx_sequencer
// Purpose  : Queues address requests and issues them one at a time on the
//            start/address_bus link, completing each on the receiver's
//            active-low ready handshake, with a watchdog on both waits.
// Revision : 1.0 - initial release
// ============================================================================
import addr_tx_pkg::*;

module addr_tx_sequencer #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_address,
  output logic              req_ready,
  output logic              start,
  output logic [ADDR_W-1:0] address_bus,
  input  logic              ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       issued_count
);

  // Wide enough to hold TIMEOUT itself, so the counter can never wrap.
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              start_q, start_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       issued_q, issued_d;

  logic              w_fifo_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [ADDR_W-1:0] w_fifo_dout;

  assign req_ready    = ~w_fifo_full;
  assign start        = start_q;
  assign address_bus  = addr_q;
  assign busy         = (state_q != IDLE);
  assign timeout_err  = tmo_q;
  assign issued_count = issued_q;

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (req_valid & req_ready),
    .pop   (w_fifo_pop),
    .din   (req_address),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Next-state logic; start_d is set on entry to ISSUE so start_q is high
  // for exactly the ISSUE cycle, and timeout_err is a one-cycle pulse.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    start_d    = 1'b0;
    tmo_d      = 1'b0;
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    w_fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_fifo_empty && !ready) begin
          w_fifo_pop = 1'b1;
          addr_d     = w_fifo_dout;
          start_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (ready) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!ready) begin
          issued_d = issued_q + 16'd1;
          state_d  = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      start_q  <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_tx_sequencer
// Purpose  : Directed self-checking bench for addr_tx_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addr_tx_sequencer;

  localparam int ADDR_W  = 11;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] req_address;
  logic              req_ready;
  logic              start;
  logic [ADDR_W-1:0] address_bus;
  logic              ready;
  logic              busy;
  logic              timeout_err;
  logic [15:0]       issued_count;

  addr_tx_sequencer #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_address  (req_address),
    .req_ready    (req_ready),
    .start        (start),
    .address_bus  (address_bus),
    .ready        (ready),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .issued_count (issued_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Receiver modes: 0 = hold ready at rx_level, 1 = normal handshake,
  // 2 = never respond, 3 = raise ready after start and never lower it.
  int   rx_mode  = 0;
  logic rx_level = 1'b0;

  logic [ADDR_W-1:0] start_log[$];
  int                start_cyc_log[$];
  int                tmo_count  = 0;
  int                tmo_cyc    = 0;
  int                last_start = -100;
  logic              prev_busy  = 1'b0;
  logic [ADDR_W-1:0] prev_addr  = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Receiver model.
  initial begin
    ready = 1'b0;
    forever begin
      @(negedge clock);
      if (start === 1'b1 && (rx_mode == 1 || rx_mode == 3)) begin
        @(posedge clock);
        #1 ready = 1'b1;
        if (rx_mode == 1) begin
          repeat (3) @(posedge clock);
          #1 ready = 1'b0;
        end
      end else if (rx_mode == 0) begin
        ready = rx_level;
      end else if (rx_mode == 1) begin
        ready = 1'b0;
      end
    end
  end

  // Link monitor: logs start pulses and timeouts, checks start spacing and
  // address stability while busy.
  initial begin
    forever begin
      @(negedge clock);
      if (start === 1'b1) begin
        checks++;
        if (cyc - last_start < 4) begin
          failures++;
          $display("FAIL start_spacing: got %0d cycles expected >=4", cyc - last_start);
        end
        last_start = cyc;
        start_log.push_back(address_bus);
        start_cyc_log.push_back(cyc);
      end
      if (timeout_err === 1'b1) begin
        tmo_count++;
        tmo_cyc = cyc;
      end
      if (prev_busy && busy) begin
        checks++;
        if (address_bus !== prev_addr) begin
          failures++;
          $display("FAIL addr_stable_busy: got 0x%0h expected 0x%0h", address_bus, prev_addr);
        end
      end
      prev_busy = busy;
      prev_addr = address_bus;
    end
  end

  // Drive one request and return the cycle number of its accepting edge.
  task automatic push(input logic [ADDR_W-1:0] a, output int hs);
    int n;
    n = 0;
    @(negedge clock);
    req_valid   = 1'b1;
    req_address = a;
    while (req_ready !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL push_wait: got req_ready=%b expected 1 within 60 cycles", req_ready);
    end
    @(posedge clock);
    #1;
    hs        = cyc;
    req_valid = 1'b0;
  endtask

  // Wait until n_target starts have been seen and the FSM is idle again.
  task automatic wait_done(input int n_target);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(start_log.size() >= n_target && busy === 1'b0) && n < 300);
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL wait_done: got %0d starts busy=%b expected %0d starts and idle",
               start_log.size(), busy, n_target);
    end
    @(negedge clock);
  endtask

  function automatic logic [ADDR_W-1:0] start_at(input int idx);
    if (idx < start_log.size()) return start_log[idx];
    return 'x;
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                mode;
    bit                exp_tmo;
    int                tmo_dly;   // start cycle to timeout pulse cycle
    logic [15:0]       exp_cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int hs;
    int n0;
    int t0;
    int c0;

    #20_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int hs;
    int n0;
    int t0;
    int c0;
    logic [ADDR_W-1:0] exp_a;

    // Busy timeout: 1 ISSUE + TIMEOUT cycles in WAIT_BUSY, pulse next cycle.
    // Done timeout: one extra cycle spent in WAIT_BUSY before WAIT_DONE.
    vecs[0] = '{addr: 11'h2A5, mode: 1, exp_tmo: 1'b0, tmo_dly: 0,           exp_cnt: 16'd1};
    vecs[1] = '{addr: 11'h7FF, mode: 2, exp_tmo: 1'b1, tmo_dly: TIMEOUT + 1, exp_cnt: 16'd1};
    vecs[2] = '{addr: 11'h100, mode: 1, exp_tmo: 1'b0, tmo_dly: 0,           exp_cnt: 16'd2};
    vecs[3] = '{addr: 11'h155, mode: 3, exp_tmo: 1'b1, tmo_dly: TIMEOUT + 2, exp_cnt: 16'd2};
    vecs[4] = '{addr: 11'h0AA, mode: 1, exp_tmo: 1'b0, tmo_dly: 0,           exp_cnt: 16'd3};

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_address = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_start",        32'(start),        32'd0);
    chk("rst_address_bus",  32'(address_bus),  32'd0);
    chk("rst_busy",         32'(busy),         32'd0);
    chk("rst_timeout_err",  32'(timeout_err),  32'd0);
    chk("rst_issued_count", 32'(issued_count), 32'd0);
    chk("rst_req_ready",    32'(req_ready),    32'd1);
    reset = 1'b0;

    // Table-driven single transfers.
    for (int i = 0; i < 5; i++) begin
      rx_mode  = 0;
      rx_level = 1'b0;
      repeat (2) @(negedge clock);
      rx_mode = vecs[i].mode;
      n0 = start_log.size();
      t0 = tmo_count;
      push(vecs[i].addr, hs);
      wait_done(n0 + 1);
      chk($sformatf("v%0d_addr", i),     32'(start_at(n0)), 32'(vecs[i].addr));
      chk($sformatf("v%0d_timeout", i),  32'(tmo_count - t0), 32'(vecs[i].exp_tmo));
      if (vecs[i].exp_tmo && start_cyc_log.size() > n0)
        chk($sformatf("v%0d_tmo_delay", i), 32'(tmo_cyc - start_cyc_log[n0]), 32'(vecs[i].tmo_dly));
      if (!vecs[i].exp_tmo && start_cyc_log.size() > n0)
        chk($sformatf("v%0d_latency", i), 32'(start_cyc_log[n0] - hs), 32'd1);
      chk($sformatf("v%0d_issued", i),   32'(issued_count), 32'(vecs[i].exp_cnt));
      repeat (5) @(negedge clock);
      chk($sformatf("v%0d_no_extra_start", i), 32'(start_log.size()), 32'(n0 + 1));
    end

    // Fill and back-pressure with the receiver holding ready high.
    rx_mode  = 0;
    rx_level = 1'b1;
    repeat (2) @(negedge clock);
    n0 = start_log.size();
    c0 = issued_count;
    for (int k = 1; k <= 4; k++) push(ADDR_W'(k), hs);
    @(negedge clock);
    chk("fill_req_ready_full", 32'(req_ready), 32'd0);
    req_valid   = 1'b1;
    req_address = 11'h005;
    repeat (3) @(negedge clock);
    chk("fill_5th_blocked", 32'(req_ready), 32'd0);
    chk("fill_no_start_while_ready_hi", 32'(start_log.size()), 32'(n0));
    req_valid = 1'b0;
    rx_mode   = 1;
    wait_done(n0 + 4);
    for (int k = 0; k < 4; k++) begin
      exp_a = ADDR_W'(k + 1);
      chk($sformatf("fill_order_%0d", k), 32'(start_at(n0 + k)), 32'(exp_a));
    end
    chk("fill_issued", 32'(issued_count), 32'(c0 + 4));
    chk("fill_req_ready_after", 32'(req_ready), 32'd1);

    // Reset while stuck in WAIT_BUSY with requests queued behind it.
    rx_mode  = 0;
    rx_level = 1'b0;
    repeat (2) @(negedge clock);
    rx_mode = 2;
    push(11'h011, hs);
    push(11'h022, hs);
    push(11'h033, hs);
    push(11'h044, hs);
    @(negedge clock);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rstmid_start",        32'(start),        32'd0);
    chk("rstmid_address_bus",  32'(address_bus),  32'd0);
    chk("rstmid_busy",         32'(busy),         32'd0);
    chk("rstmid_req_ready",    32'(req_ready),    32'd1);
    chk("rstmid_issued_count", 32'(issued_count), 32'd0);
    rx_mode = 0;
    n0 = start_log.size();
    repeat (30) @(negedge clock);
    chk("rstmid_queue_discarded", 32'(start_log.size()), 32'(n0));
    rx_mode = 1;
    push(11'h3C3, hs);
    wait_done(n0 + 1);
    chk("rstmid_new_addr",   32'(start_at(n0)), 32'h3C3);
    chk("rstmid_new_issued", 32'(issued_count), 32'd1);

    // Completion counter wrap.
    force dut.issued_q = 16'hFFFF;
    repeat (2) @(posedge clock);
    release dut.issued_q;
    @(negedge clock);
    chk("wrap_preload", 32'(issued_count), 32'hFFFF);
    n0 = start_log.size();
    push(11'h555, hs);
    wait_done(n0 + 1);
    chk("wrap_addr",   32'(start_at(n0)), 32'h555);
    chk("wrap_issued", 32'(issued_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
